core_fifo_pack: RTL and testbench

Width-up-converting FIFO: accepts narrow words on the write side and packs each group of Ratio words into one wide entry. Emits whole wide entries on the read side. It is the gather counterpart to the core width-down FIFO. Used where narrow producers feed wide consumers, e.g. pixel bytes into 32-bit accumulator/weight buffers.

---
 rtl/core_fifo_pkg.sv | 25 ++
 rtl/core_fifo_packer.sv | 66 ++++++
 rtl/core_fifo_pack.sv | 112 +++++++++++
 tb/tb_core_fifo_pack.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_fifo_pkg.sv
// ============================================================================
// core_fifo_pkg : width/ratio helpers shared by the core width-converting FIFOs
// Rev 1.0
// ============================================================================
`default_nettype none

package core_fifo_pkg;

  // Narrow-to-wide ratio; only meaningful when ratio_is_valid() holds.
  function automatic int calc_ratio(input int in_bits, input int out_bits);
    return out_bits / in_bits;
  endfunction

  function automatic bit ratio_is_valid(input int in_bits, input int out_bits);
    return (in_bits > 0) && (out_bits >= in_bits) && ((out_bits % in_bits) == 0);
  endfunction

  // Index width for a counter over n positions, never narrower than 1 bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_fifo_packer.sv
// ============================================================================
// core_fifo_packer : gathers Ratio narrow words into one wide word + commit
// Rev 1.0
// ============================================================================
`default_nettype none

module core_fifo_packer
  import core_fifo_pkg::*;
#(
  parameter int InputBits  = 8,
  parameter int OutputBits = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [InputBits-1:0]  data_i,
  input  logic                  flush_i,
  output logic                  commit_o,
  output logic [OutputBits-1:0] word_o
);

  localparam int Ratio = calc_ratio(InputBits, OutputBits);
  localparam int OffW  = idx_bits(Ratio);

  logic [OutputBits-1:0] pack_q, pack_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [OutputBits-1:0] w_merged;
  logic                  w_last;

  // pack_q is cleared on every commit, so slices above off_q are always zero.
  always_comb begin
    w_merged = pack_q;
    if (wr_i) begin
      w_merged[InputBits*off_q +: InputBits] = data_i;
    end
  end

  assign w_last   = (off_q == OffW'(Ratio - 1));
  assign commit_o = (wr_i && w_last) || (flush_i && ((off_q != '0) || wr_i));
  assign word_o   = w_merged;

  always_comb begin
    pack_d = pack_q;
    off_d  = off_q;
    if (commit_o) begin
      pack_d = '0;
      off_d  = '0;
    end else if (wr_i) begin
      pack_d = w_merged;
      off_d  = off_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pack_q <= '0;
      off_q  <= '0;
    end else begin
      pack_q <= pack_d;
      off_q  <= off_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_fifo_pack.sv
// ============================================================================
// core_fifo_pack : width-up FIFO, packs narrow writes into wide entries.
// Optional partial-pack flush port enabled by CORE_FIFO_PACK_FLUSH_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module core_fifo_pack
  import core_fifo_pkg::*;
#(
  parameter int InputBits  = 8,
  parameter int OutputBits = 32,
  parameter int Depth      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         write_en_i,
  input  logic [InputBits-1:0]         data_i,
  input  logic                         read_en_i,
`ifdef CORE_FIFO_PACK_FLUSH_EN
  input  logic                         flush_i,
`endif
  output logic [OutputBits-1:0]        data_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = idx_bits(Depth);
  localparam int CntW = $clog2(Depth + 1);

  if (!ratio_is_valid(InputBits, OutputBits) || (Depth < 1)) begin : g_param_check
    $error("core_fifo_pack: OutputBits must be a positive multiple of InputBits and Depth >= 1");
  end

  logic [OutputBits-1:0] store_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [OutputBits-1:0] data_q;
  logic                  valid_q;

  logic                  w_wr, w_rd, w_flush, w_commit;
  logic [OutputBits-1:0] w_word;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  assign w_wr = write_en_i && !full_o;
  assign w_rd = read_en_i && !empty_o;

`ifdef CORE_FIFO_PACK_FLUSH_EN
  // A flush while full is ignored so the partial pack survives.
  assign w_flush = flush_i && !full_o;
`else
  assign w_flush = 1'b0;
`endif

  core_fifo_packer #(
    .InputBits  (InputBits),
    .OutputBits (OutputBits)
  ) u_packer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (w_wr),
    .data_i   (data_i),
    .flush_i  (w_flush),
    .commit_o (w_commit),
    .word_o   (w_word)
  );

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Commit implies !full (write and flush are both gated), so no overwrite.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_commit) begin
      store_q[wr_ptr_q] <= w_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= w_rd;
      if (w_commit) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (w_rd) begin
        data_q   <= store_q[rd_ptr_q];
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (w_commit && !w_rd) begin
        count_q <= count_q + 1'b1;
      end else if (w_rd && !w_commit) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_fifo_pack.sv
// ============================================================================
// tb_core_fifo_pack : directed self-checking bench for core_fifo_pack (8->32, depth 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_fifo_pack;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        write_en_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic        read_en_i = 1'b0;
`ifdef CORE_FIFO_PACK_FLUSH_EN
  logic        flush_i = 1'b0;
`endif
  logic [31:0] data_o;
  logic        valid_o;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  core_fifo_pack #(
    .InputBits  (8),
    .OutputBits (32),
    .Depth      (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .write_en_i (write_en_i),
    .data_i     (data_i),
    .read_en_i  (read_en_i),
`ifdef CORE_FIFO_PACK_FLUSH_EN
    .flush_i    (flush_i),
`endif
    .data_o     (data_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    write_en_i = 1'b1;
    data_i     = b;
    tick();
    write_en_i = 1'b0;
  endtask

  task automatic rd();
    read_en_i = 1'b1;
    tick();
    read_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", data_o); end
  endtask

  task automatic test_basic_pack();
    wr(8'h11); wr(8'h22); wr(8'h33);
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL basic_partial_empty got=%b exp=1", empty_o); end
    wr(8'h44);
    total++; if (empty_o !== 1'b0) begin bad++; $display("FAIL basic_commit_empty got=%b exp=0", empty_o); end
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count_o); end
    rd();
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid_o); end
    total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL basic_data got=%h exp=44332211", data_o); end
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse got=%b exp=0", valid_o); end
    total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL basic_data_hold got=%h exp=44332211", data_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL basic_empty_after got=%b exp=1", empty_o); end
  endtask

  task automatic test_full_drop();
    logic [31:0] exp [4];
    exp[0] = 32'h03020100; exp[1] = 32'h07060504;
    exp[2] = 32'h0B0A0908; exp[3] = 32'h0F0E0D0C;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 14) begin
        total++; if (full_o !== 1'b0) begin bad++; $display("FAIL full_early got=%b exp=0", full_o); end
      end
    end
    total++; if (full_o !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", full_o); end
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count_o); end
    wr(8'hFF);
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_drop_count got=%0d exp=4", count_o); end
    read_en_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (valid_o !== 1'b1 || data_o !== exp[k]) begin
        bad++; $display("FAIL full_read%0d got=%h/%b exp=%h/1", k, data_o, valid_o, exp[k]);
      end
    end
    read_en_i = 1'b0;
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b exp=1", empty_o); end
    // A dropped write must not have advanced the pack offset.
    wr(8'hA0); wr(8'hA1); wr(8'hA2); wr(8'hA3);
    rd();
    total++; if (data_o !== 32'hA3A2A1A0) begin bad++; $display("FAIL full_drop_offset got=%h exp=A3A2A1A0", data_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    wr(8'h20); wr(8'h21); wr(8'h22);
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=2", count_o); end
    write_en_i = 1'b1; data_i = 8'h23; read_en_i = 1'b1;
    tick();
    write_en_i = 1'b0; read_en_i = 1'b0;
    total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count_o); end
    total++; if (valid_o !== 1'b1 || data_o !== 32'h13121110) begin
      bad++; $display("FAIL b2b_read0 got=%h/%b exp=13121110/1", data_o, valid_o);
    end
    rd();
    total++; if (data_o !== 32'h17161514) begin bad++; $display("FAIL b2b_read1 got=%h exp=17161514", data_o); end
    rd();
    total++; if (data_o !== 32'h23222120) begin bad++; $display("FAIL b2b_read2 got=%h exp=23222120", data_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_reset_partial();
    wr(8'hAA); wr(8'hBB);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if (count_o !== 3'd0 || data_o !== 32'h0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL rstp_state got=%0d/%h/%b exp=0/00000000/0", count_o, data_o, valid_o);
    end
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    rd();
    total++; if (data_o !== 32'h04030201) begin bad++; $display("FAIL rstp_data got=%h exp=04030201", data_o); end
  endtask

  task automatic test_empty_read_and_wrap();
    logic [31:0] e;
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    rd();
    total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL wrap_setup got=%h exp=44332211", data_o); end
    rd();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL empty_read_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 32'h44332211) begin bad++; $display("FAIL empty_read_data got=%h exp=44332211", data_o); end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) wr(8'(8'h40 * (p + 1) + i));
      total++; if (full_o !== 1'b1) begin bad++; $display("FAIL wrap%0d_full got=%b exp=1", p, full_o); end
      for (int k = 0; k < 4; k++) begin
        e = {8'(8'h40 * (p + 1) + 4 * k + 3), 8'(8'h40 * (p + 1) + 4 * k + 2),
             8'(8'h40 * (p + 1) + 4 * k + 1), 8'(8'h40 * (p + 1) + 4 * k)};
        rd();
        total++; if (data_o !== e) begin bad++; $display("FAIL wrap%0d_read%0d got=%h exp=%h", p, k, data_o, e); end
      end
      total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL wrap%0d_empty got=%b exp=1", p, empty_o); end
    end
  endtask

`ifdef CORE_FIFO_PACK_FLUSH_EN
  task automatic test_flush();
    wr(8'h01); wr(8'h02);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL flush_count got=%0d exp=1", count_o); end
    rd();
    total++; if (data_o !== 32'h00000201) begin bad++; $display("FAIL flush_data got=%h exp=00000201", data_o); end
    wr(8'h03); wr(8'h04); wr(8'h05); wr(8'h06);
    rd();
    total++; if (data_o !== 32'h06050403) begin bad++; $display("FAIL flush_after got=%h exp=06050403", data_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pack();
    test_full_drop();
    test_back_to_back();
    test_reset_partial();
    test_empty_read_and_wrap();
`ifdef CORE_FIFO_PACK_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
